// File: rtl/ones_count_sequencer_pkg.sv
// Shared types and constants for the time-multiplexed ones counter.
// Holds the FSM state type, the slice width and the count-width helper.
package ocseq_pkg;

    localparam int SLICE_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ocseq_state_e;

    // Result width: enough bits to hold 15*slices itself.
    function automatic int cw_of(input int slices);
        return $clog2(SLICE_W * slices + 1);
    endfunction

endpackage

// File: rtl/ones_count_sequencer_if.sv
// Producer/consumer handshake bundle for ones_count_sequencer.
// The SLICES value must match the one given to the sequencer instance.
interface ones_count_sequencer_if
    import ocseq_pkg::*;
#(
    parameter int SLICES = 4
);
    localparam int W  = SLICE_W * SLICES;
    localparam int CW = cw_of(SLICES);

    logic          clear;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          out_ready;
    logic          busy;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, busy
    );

endinterface

// File: rtl/myoc15input.sv
// Combinational 15-input ones counter: y3..y0 is the number of set inputs.
// Five full adders compress the inputs into weight-1 and weight-2 bit groups.
module myoc15input (
    input  logic a, b, c, d, e, f, g, h, i, j, k, l, m, n, o,
    output logic y0, y1, y2, y3
);

    logic [4:0] s;
    logic [4:0] cy;
    logic [3:0] w1;
    logic [3:0] w2;
    logic [3:0] total;

    assign s[0]  = a ^ b ^ c;
    assign cy[0] = (a & b) | (c & (a ^ b));
    assign s[1]  = d ^ e ^ f;
    assign cy[1] = (d & e) | (f & (d ^ e));
    assign s[2]  = g ^ h ^ i;
    assign cy[2] = (g & h) | (i & (g ^ h));
    assign s[3]  = j ^ k ^ l;
    assign cy[3] = (j & k) | (l & (j ^ k));
    assign s[4]  = m ^ n ^ o;
    assign cy[4] = (m & n) | (o & (m ^ n));

    // w1 <= 5 and w2 <= 5, so w1 + 2*w2 <= 15 fits in four bits.
    assign w1 = 4'(s[0]) + 4'(s[1]) + 4'(s[2]) + 4'(s[3]) + 4'(s[4]);
    assign w2 = 4'(cy[0]) + 4'(cy[1]) + 4'(cy[2]) + 4'(cy[3]) + 4'(cy[4]);
    assign total = w1 + {w2[2:0], 1'b0};

    assign {y3, y2, y1, y0} = total;

endmodule

// File: rtl/ones_count_sequencer.sv
// Population count of a 15*SLICES-bit word using one shared 15-input counter,
// fed one slice per cycle from a shift register and summed into an accumulator.
module ones_count_sequencer
    import ocseq_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ones_count_sequencer_if.slave   bus
);

    localparam int W  = SLICE_W * SLICES;
    localparam int CW = cw_of(SLICES);
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    ocseq_state_e  state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    cnt4;

    myoc15input u_oc15 (
        .a (sr_q[0]),  .b (sr_q[1]),  .c (sr_q[2]),  .d (sr_q[3]),
        .e (sr_q[4]),  .f (sr_q[5]),  .g (sr_q[6]),  .h (sr_q[7]),
        .i (sr_q[8]),  .j (sr_q[9]),  .k (sr_q[10]), .l (sr_q[11]),
        .m (sr_q[12]), .n (sr_q[13]), .o (sr_q[14]),
        .y0 (cnt4[0]), .y1 (cnt4[1]), .y2 (cnt4[2]), .y3 (cnt4[3])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        // clear outranks acceptance, accumulation and the output handshake.
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr_d    = bus.in_data;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = acc_q + CW'(cnt4);
                    sr_d  = sr_q >> SLICE_W;
                    if (idx_q == IW'(SLICES - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_count = acc_q;

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Self-checking bench for ones_count_sequencer with SLICES=4 and SLICES=1 builds.
module tb_ones_count_sequencer;
    import ocseq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ones_count_sequencer_if #(.SLICES(4)) bus ();
    ones_count_sequencer_if #(.SLICES(1)) bus1 ();

    ones_count_sequencer #(.SLICES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    ones_count_sequencer #(.SLICES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [59:0] data;
        int          hold;
        int          exp_count;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count set bits one at a time over the whole word.
    function automatic int ref_count(input logic [59:0] w, input int nbits);
        int c = 0;
        for (int b = 0; b < nbits; b++) c += int'(w[b]);
        return c;
    endfunction

    function automatic logic [59:0] rnd60();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[59:0];
    endfunction

    task automatic run_word(input logic [59:0] data, input int hold, input int exp, input string name);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        check({name, " in_ready before accept"}, bus.in_ready, 1);
        bus.in_data   = data;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = rnd60();
        check({name, " busy after accept"}, bus.busy, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
            bus.in_data = rnd60();
        end
        check({name, " latency"}, n, 4);
        check({name, " out_count"}, bus.out_count, exp);
        check({name, " in_ready low in DONE"}, bus.in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, " held out_valid"}, bus.out_valid, 1);
            check({name, " held out_count"}, bus.out_count, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, " out_valid after handshake"}, bus.out_valid, 0);
        check({name, " in_ready after handshake"}, bus.in_ready, 1);
    endtask

    task automatic run_word1(input logic [14:0] data, input int exp, input string name);
        int n;
        bus1.in_data  = data;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        bus1.in_data  = 15'($urandom());
        check({name, " busy"}, bus1.busy, 1);
        n = 0;
        while (!bus1.out_valid && n < 20) begin tick(); n++; end
        check({name, " latency"}, n, 1);
        check({name, " out_count"}, bus1.out_count, exp);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check({name, " in_ready after handshake"}, bus1.in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        logic [59:0] w;
        int n;
        int seen;

        vecs[0] = '{60'hFFFFFFFFFFFFFFF, 0, 60};
        vecs[1] = '{60'h000000000000000, 0, 0};
        vecs[2] = '{60'h800000000000001, 0, 2};
        vecs[3] = '{60'h00000000000FFFF, 10, 16};
        vecs[4] = '{60'h000000000000007, 0, 3};
        vecs[5] = '{60'hAAAAAAAAAAAAAAA, 2, 30};
        vecs[6] = '{60'h000000000007FFF, 1, 15};
        vecs[7] = '{60'h800000000000000, 0, 1};

        rst = 1'b1;
        bus.clear = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
        bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        #2;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_count", bus.out_count, 0);
        check("reset busy", bus.busy, 0);
        #10 rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_word(vecs[v].data, vecs[v].hold, vecs[v].exp_count, $sformatf("vec%0d", v));
        end

        // Back-to-back with in_valid held high: no accept in the DONE-to-IDLE cycle.
        bus.in_data  = 60'h0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 60'h800000000000001;
        for (int c = 0; c < 4; c++) tick();
        check("b2b first out_valid", bus.out_valid, 1);
        check("b2b first out_count", bus.out_count, 0);
        check("b2b in_ready in DONE", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("b2b idle after handshake", bus.in_ready, 1);
        check("b2b no accept in return cycle", bus.busy, 0);
        tick();
        bus.in_valid = 1'b0;
        check("b2b second accepted", bus.busy, 1);
        for (int c = 0; c < 4; c++) tick();
        check("b2b second out_valid", bus.out_valid, 1);
        check("b2b second out_count", bus.out_count, 2);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Async reset during the second RUN cycle of an all-ones word.
        bus.in_data  = 60'hFFFFFFFFFFFFFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst mid-run in_ready", bus.in_ready, 1);
        check("rst mid-run out_valid", bus.out_valid, 0);
        check("rst mid-run out_count", bus.out_count, 0);
        check("rst mid-run busy", bus.busy, 0);
        #2 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin tick(); seen |= int'(bus.out_valid); end
        check("rst no partial result", seen, 0);
        run_word(60'h7, 0, 3, "after rst");

        // clear during RUN aborts the word.
        bus.in_data  = 60'hFFFFFFFFFFFFFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear run in_ready", bus.in_ready, 1);
        check("clear run busy", bus.busy, 0);
        check("clear run out_count", bus.out_count, 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin tick(); seen |= int'(bus.out_valid); end
        check("clear run no out_valid", seen, 0);

        // clear together with in_valid in IDLE: no acceptance.
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 60'hFFFFFFFFFFFFFFF;
        tick();
        check("clear+valid in_ready", bus.in_ready, 1);
        check("clear+valid busy", bus.busy, 0);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("clear+valid still idle", bus.busy, 0);
        run_word(60'h000F00000000F00, 0, 8, "after clear");

        // clear in DONE discards the held result.
        bus.in_data  = 60'h3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("clear done reached DONE", bus.out_valid, 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear done out_valid", bus.out_valid, 0);
        check("clear done out_count", bus.out_count, 0);
        check("clear done in_ready", bus.in_ready, 1);

        // Randomized words against the reference model.
        for (int r = 0; r < 40; r++) begin
            w = rnd60();
            case ($urandom_range(0, 3))
                0: w = w & rnd60() & rnd60();
                1: w = w | rnd60() | rnd60();
                default: ;
            endcase
            run_word(w, int'($urandom_range(0, 3)), ref_count(w, 60), $sformatf("rand%0d", r));
        end

        // SLICES=1 build.
        check("s1 reset in_ready", bus1.in_ready, 1);
        run_word1(15'h7FFF, 15, "s1 all ones");
        for (int r = 0; r < 10; r++) begin
            w = rnd60();
            run_word1(w[14:0], ref_count({45'b0, w[14:0]}, 15), $sformatf("s1 rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
